// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master burst arbiter: FSM encoding,
// master indices and address-region constants.
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int          ADDR_STEP_DFLT = 4;
    localparam logic [31:0] REGION_MASK    = 32'hF000_0000;

endpackage

// File: rtl/rr_pick.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes
// to the master that did not own the bus last.
module rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner
);

    always_comb begin
        winner = M0;
        if (req[1] && !req[0]) begin
            winner = M1;
        end else if (req[1] && req[0]) begin
            winner = ~last_owner;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master burst arbiter (m0 = CPU, m1 = DMA) driving one I/O slave port.
// Bursts are incrementing, may not cross a 256 MB region, and are separated by an IDLE cycle.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int BEATS_MAX = 16,
    parameter int ADDR_STEP = ADDR_STEP_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [3:0]  m0_len,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [3:0]  m1_len,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic        m0_rvalid,
    output logic        m0_err,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic        m1_rvalid,
    output logic        m1_err,
    output logic [31:0] rdata,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2(BEATS_MAX);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [3:0]       len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [1:0]       err_q, err_d;

    logic        winner;
    logic [31:0] next_addr;
    logic        crosses_region;
    logic        last_beat;
    logic        busy;

    rr_pick u_rr_pick (
        .req        ({m1_req, m0_req}),
        .last_owner (last_owner_q),
        .winner     (winner)
    );

    assign next_addr      = addr_q + 32'(ADDR_STEP);
    assign crosses_region = ((next_addr ^ addr_q) & REGION_MASK) != 32'h0;
    assign last_beat      = int'(cnt_q) == int'(len_q);

    always_comb begin
        // NOTE: every _d takes its hold value first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        rvalid_d     = 2'b00;
        err_d        = 2'b00;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d      = BUSY;
                    owner_d      = winner;
                    last_owner_d = winner;
                    addr_d       = (winner == M1) ? m1_addr : m0_addr;
                    we_d         = (winner == M1) ? m1_we   : m0_we;
                    len_d        = (winner == M1) ? m1_len  : m0_len;
                    cnt_d        = '0;
                end
            end
            BUSY: begin
                rvalid_d[owner_q] = !we_q;
                cnt_d             = cnt_q + CNT_W'(1);
                addr_d            = next_addr;
                // Stop before the next beat would land in a different region.
                if (last_beat || crosses_region) begin
                    state_d        = IDLE;
                    err_d[owner_q] = !last_beat;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples the pre-edge values computed above.
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= M0;
            last_owner_q <= M1;
            addr_q       <= '0;
            we_q         <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            rvalid_q     <= 2'b00;
            err_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
        end
    end

    assign busy      = state_q == BUSY;
    assign m0_gnt    = busy && (owner_q == M0);
    assign m1_gnt    = busy && (owner_q == M1);
    assign m0_ack    = m0_gnt;
    assign m1_ack    = m1_gnt;
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign rdata     = (|rvalid_q) ? bus_rdata : 32'h0;

    assign bus_addr  = busy ? addr_q : 32'h0;
    assign bus_we    = busy && we_q;
    assign bus_wdata = !(busy && we_q) ? 32'h0 :
                       (owner_q == M1) ? m1_wdata : m0_wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: each task drives one scenario cycle by cycle
// and compares the outputs against hand-derived expectations.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [3:0]  m0_len = '0, m1_len = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m0_ack, m0_rvalid, m0_err;
    logic        m1_gnt, m1_ack, m1_rvalid, m1_err;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
    logic        bus_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Slave model: one-cycle read latency, data equals the address read.
    logic [31:0] slave_q = '0;
    always @(posedge clk) slave_q <= bus_addr;
    assign bus_rdata = slave_q;

    bus_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_we     (m0_we),
        .m0_len    (m0_len),
        .m0_wdata  (m0_wdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_we     (m1_we),
        .m1_len    (m1_len),
        .m1_wdata  (m1_wdata),
        .m0_gnt    (m0_gnt),
        .m0_ack    (m0_ack),
        .m0_rvalid (m0_rvalid),
        .m0_err    (m0_err),
        .m1_gnt    (m1_gnt),
        .m1_ack    (m1_ack),
        .m1_rvalid (m1_rvalid),
        .m1_err    (m1_err),
        .rdata     (rdata),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_len = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_len = '0; m1_wdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #3;
        checks++;
        if ({m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rvalid, m1_rvalid, m0_err, m1_err, bus_we} !== 9'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000000",
                     {m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rvalid, m1_rvalid, m0_err, m1_err, bus_we});
        end
        checks++;
        if ({bus_addr, bus_wdata, rdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h wdata=%h rdata=%h exp all 0", bus_addr, bus_wdata, rdata);
        end
        tick();
    endtask

    // m0 read of 4 beats at 0x100; req dropped right after grant.
    task automatic test_read_burst;
        logic [67:0] obs, exp_v;
        logic        g, rv;
        m0_req = 1'b1; m0_addr = 32'h100; m0_we = 1'b0; m0_len = 4'd3;
        for (int c = 0; c <= 6; c++) begin
            if (c == 1) m0_req = 1'b0;
            #3;
            g     = (c >= 1) && (c <= 4);
            rv    = (c >= 2) && (c <= 5);
            exp_v = {g, g, 1'b0, g ? 32'h100 + 32'(4 * (c - 1)) : 32'h0,
                     rv, rv ? 32'h100 + 32'(4 * (c - 2)) : 32'h0};
            obs   = {m0_gnt, m0_ack, bus_we, bus_addr, m0_rvalid, rdata};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL read_burst c=%0d got %h exp %h", c, obs, exp_v);
            end
            tick();
        end
    endtask

    // Both masters request single-beat reads from reset: m0, m1, m0.
    task automatic test_tie;
        logic [3:0]  tf [8] = '{4'b0000, 4'b1000, 4'b0010, 4'b0100,
                                4'b0001, 4'b1000, 4'b0010, 4'b0000};
        logic [31:0] ta [8] = '{32'h0, 32'h200, 32'h0, 32'h300,
                                32'h0, 32'h200, 32'h0, 32'h0};
        logic [35:0] obs, exp_v;
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h200; m0_len = 4'd0;
        m1_req = 1'b1; m1_addr = 32'h300; m1_len = 4'd0;
        for (int c = 0; c <= 7; c++) begin
            if (c == 5) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            #3;
            exp_v = {tf[c], ta[c]};
            obs   = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_addr};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL tie_rr c=%0d got %h exp %h", c, obs, exp_v);
            end
            tick();
        end
    endtask

    // m1 write of 4 beats at 0x0FFFFFF8 is cut at the region boundary.
    task automatic test_truncate;
        logic [68:0] tv [5] = '{
            69'h0,
            {3'b111, 32'h0FFF_FFF8, 32'hA0, 2'b00},
            {3'b111, 32'h0FFF_FFFC, 32'hA1, 2'b00},
            {3'b000, 32'h0,         32'h0,  2'b10},
            69'h0};
        logic [68:0] obs;
        m0_wdata = 32'hDEAD_BEEF;
        m1_req = 1'b1; m1_addr = 32'h0FFF_FFF8; m1_we = 1'b1; m1_len = 4'd3;
        for (int c = 0; c <= 4; c++) begin
            if (c == 1) m1_req = 1'b0;
            m1_wdata = 32'hA0 + 32'((c >= 1) ? c - 1 : 0);
            #3;
            obs = {m1_gnt, m1_ack, bus_we, bus_addr, bus_wdata, m1_err, m1_rvalid};
            checks++;
            if (obs !== tv[c]) begin
                errors++;
                $display("FAIL truncate c=%0d got %h exp %h", c, obs, tv[c]);
            end
            tick();
        end
        idle_inputs();
    endtask

    // m1 write of 8 beats aborted by reset during beat 2; tie afterwards goes to m0.
    task automatic test_reset_mid_burst;
        logic [8:0]  tf [8] = '{9'b000000000, 9'b010110000, 9'b010110000, 9'b010110000,
                                9'b000000000, 9'b101000000, 9'b000001000, 9'b000000000};
        logic [31:0] ta [8] = '{32'h0, 32'h2000, 32'h2004, 32'h2008,
                                32'h0, 32'h600, 32'h0, 32'h0};
        logic [40:0] obs, exp_v;
        m1_req = 1'b1; m1_addr = 32'h2000; m1_we = 1'b1; m1_len = 4'd7; m1_wdata = 32'h55;
        for (int c = 0; c <= 7; c++) begin
            case (c)
                1: m1_req = 1'b0;
                3: rst = 1'b1;
                4: begin
                    rst = 1'b0;
                    m0_req = 1'b1; m0_addr = 32'h600; m0_we = 1'b0; m0_len = 4'd0;
                    m1_req = 1'b1; m1_addr = 32'h700; m1_we = 1'b0; m1_len = 4'd0;
                end
                5: begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
                default: ;
            endcase
            #3;
            exp_v = {tf[c], ta[c]};
            obs   = {m0_gnt, m1_gnt, m0_ack, m1_ack, bus_we, m0_rvalid, m1_rvalid,
                     m0_err, m1_err, bus_addr};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid c=%0d got %h exp %h", c, obs, exp_v);
            end
            tick();
        end
        idle_inputs();
    endtask

    // m0 read of 6 beats with req dropped after grant; m1 waits for the IDLE gap.
    task automatic test_back_to_back;
        logic [70:0] obs, exp_v;
        logic        g0, rv0, g1, rv1;
        logic [31:0] ea, ed;
        m0_req = 1'b1; m0_addr = 32'h400; m0_we = 1'b0; m0_len = 4'd5;
        for (int c = 0; c <= 10; c++) begin
            if (c == 1) begin
                m0_req = 1'b0;
                m1_req = 1'b1; m1_addr = 32'h500; m1_we = 1'b0; m1_len = 4'd0;
            end
            if (c == 8) m1_req = 1'b0;
            #3;
            g0  = (c >= 1) && (c <= 6);
            rv0 = (c >= 2) && (c <= 7);
            g1  = c == 8;
            rv1 = c == 9;
            ea  = g0 ? 32'h400 + 32'(4 * (c - 1)) : (g1 ? 32'h500 : 32'h0);
            ed  = rv0 ? 32'h400 + 32'(4 * (c - 2)) : (rv1 ? 32'h500 : 32'h0);
            exp_v = {g0, g0, rv0, g1, g1, rv1, 1'b0, ea, ed};
            obs   = {m0_gnt, m0_ack, m0_rvalid, m1_gnt, m1_ack, m1_rvalid, bus_we, bus_addr, rdata};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back c=%0d got %h exp %h", c, obs, exp_v);
            end
            tick();
        end
        idle_inputs();
    endtask

    // m0 read at 0xFFFFFFFC: next address wraps into region 0, so one beat plus err.
    task automatic test_top_of_map;
        logic [67:0] tv [4] = '{
            68'h0,
            {2'b11, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0},
            {2'b00, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1},
            68'h0};
        logic [67:0] obs;
        m0_req = 1'b1; m0_addr = 32'hFFFF_FFFC; m0_we = 1'b0; m0_len = 4'd1;
        for (int c = 0; c <= 3; c++) begin
            if (c == 1) m0_req = 1'b0;
            #3;
            obs = {m0_gnt, m0_ack, bus_addr, m0_rvalid, rdata, m0_err};
            checks++;
            if (obs !== tv[c]) begin
                errors++;
                $display("FAIL top_of_map c=%0d got %h exp %h", c, obs, tv[c]);
            end
            tick();
        end
        idle_inputs();
    endtask

    // m0 write carrying across a 64 KB line inside region 3: no truncation.
    task automatic test_internal_carry;
        logic [68:0] tv [5] = '{
            69'h0,
            {3'b111, 32'h3000_FFF8, 32'hB0, 2'b00},
            {3'b111, 32'h3000_FFFC, 32'hB1, 2'b00},
            {3'b111, 32'h3001_0000, 32'hB2, 2'b00},
            69'h0};
        logic [68:0] obs;
        m1_wdata = 32'h1234_5678;
        m0_req = 1'b1; m0_addr = 32'h3000_FFF8; m0_we = 1'b1; m0_len = 4'd2;
        for (int c = 0; c <= 4; c++) begin
            if (c == 1) m0_req = 1'b0;
            m0_wdata = 32'hB0 + 32'((c >= 1) ? c - 1 : 0);
            #3;
            obs = {m0_gnt, m0_ack, bus_we, bus_addr, bus_wdata, m0_err, m0_rvalid};
            checks++;
            if (obs !== tv[c]) begin
                errors++;
                $display("FAIL internal_carry c=%0d got %h exp %h", c, obs, tv[c]);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired after 100000 time units");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_burst();
        test_tie();
        test_truncate();
        test_reset_mid_burst();
        test_back_to_back();
        test_top_of_map();
        test_internal_carry();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
